// File: rtl/fifo_arb_tx_if.sv
// Source-FIFO / sink-FIFO handshake bundle for fifo_arb_tx.
// master = arbiter side, slave = FIFO environment side.
interface fifo_arb_tx_if #(
    parameter int unsigned DW = 32
) ();
    logic          f1_rd_en_o;
    logic [DW-1:0] f1_rd_data_i;
    logic          f1_empty_i;
    logic          f2_rd_en_o;
    logic [DW-1:0] f2_rd_data_i;
    logic          f2_empty_i;
    logic          wr_en_o;
    logic [DW-1:0] wr_data_o;
    logic          full_i;

    modport master (
        output f1_rd_en_o,
        input  f1_rd_data_i,
        input  f1_empty_i,
        output f2_rd_en_o,
        input  f2_rd_data_i,
        input  f2_empty_i,
        output wr_en_o,
        output wr_data_o,
        input  full_i
    );

    modport slave (
        input  f1_rd_en_o,
        output f1_rd_data_i,
        output f1_empty_i,
        input  f2_rd_en_o,
        output f2_rd_data_i,
        output f2_empty_i,
        input  wr_en_o,
        input  wr_data_o,
        output full_i
    );
endinterface

// File: rtl/fifo_arb_tx.sv
// Transmit packet arbiter: round-robin merge of two FWFT source FIFOs into one
// sink, forwarding whole packets and tagging each command with its source.
module fifo_arb_tx #(
    parameter int unsigned   DW        = 32,
    parameter logic [DW-1:0] SEL_MASK  = DW'(32'h8000_0000),
    parameter int unsigned   CNT_SHIFT = 24,
    parameter logic [3:0]    CNT_MASK  = 4'hf
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    fifo_arb_tx_if.master        bus_if,
    output logic [1:0]           gnt_o,
    output logic [15:0]          pkt_cnt1_o,
    output logic [15:0]          pkt_cnt2_o
);
    localparam int unsigned REM_W  = 4;
    localparam int unsigned PCNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                last_src1_q, last_src1_d;
    logic [PCNT_W-1:0]   cnt1_q, cnt1_d;
    logic [PCNT_W-1:0]   cnt2_q, cnt2_d;

    logic                pick1_c, pick2_c;
    logic                pop1_c, pop2_c;
    logic                done_c;
    logic [DW-1:0]       wr_data_c;
    logic [DW-1:0]       head_c;
    logic [REM_W-1:0]    len_c;

    // Data-word count carried in a command; unknown codes mean no payload.
    function automatic logic [REM_W-1:0] decode_len(input logic [DW-1:0] cmd);
        logic [3:0] code;
        code = 4'(cmd >> CNT_SHIFT) & CNT_MASK;
        case (code)
            4'd1:    decode_len = REM_W'(1);
            4'd2:    decode_len = REM_W'(2);
            4'd3:    decode_len = REM_W'(4);
            4'd4:    decode_len = REM_W'(8);
            default: decode_len = '0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            gnt_q       <= '0;
            last_src1_q <= 1'b0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            gnt_q       <= gnt_d;
            last_src1_q <= last_src1_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
        end
    end

    // Output decode; reset gates the pass-through paths so nothing moves while held.
    always_comb begin
        pick1_c   = 1'b0;
        pick2_c   = 1'b0;
        pop1_c    = 1'b0;
        pop2_c    = 1'b0;
        wr_data_c = '0;
        if (rstn_i) begin
            case (state_q)
                ST_IDLE: begin
                    pick1_c = !bus_if.f1_empty_i && (bus_if.f2_empty_i || !last_src1_q);
                    pick2_c = !bus_if.f2_empty_i && !pick1_c;
                    pop1_c  = pick1_c && !bus_if.full_i;
                    pop2_c  = pick2_c && !bus_if.full_i;
                    if (pop1_c) begin
                        wr_data_c = bus_if.f1_rd_data_i | SEL_MASK;
                    end else if (pop2_c) begin
                        wr_data_c = bus_if.f2_rd_data_i & ~SEL_MASK;
                    end
                end
                ST_DATA: begin
                    pop1_c = gnt_q[0] && !bus_if.f1_empty_i && !bus_if.full_i;
                    pop2_c = gnt_q[1] && !bus_if.f2_empty_i && !bus_if.full_i;
                    if (pop1_c) begin
                        wr_data_c = bus_if.f1_rd_data_i;
                    end else if (pop2_c) begin
                        wr_data_c = bus_if.f2_rd_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Length is decoded from the raw source word, before select tagging.
    assign head_c = pop2_c ? bus_if.f2_rd_data_i : bus_if.f1_rd_data_i;
    assign len_c  = decode_len(head_c);

    // Next-state and packet bookkeeping
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        gnt_d       = gnt_q;
        last_src1_d = last_src1_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        done_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop1_c || pop2_c) begin
                    if (len_c == '0) begin
                        done_c = 1'b1;
                    end else begin
                        rem_d   = len_c;
                        gnt_d   = {pop2_c, pop1_c};
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pop1_c || pop2_c) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        done_c  = 1'b1;
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase
        if (done_c) begin
            if (pop1_c) begin
                cnt1_d      = cnt1_q + PCNT_W'(1);
                last_src1_d = 1'b1;
            end else begin
                cnt2_d      = cnt2_q + PCNT_W'(1);
                last_src1_d = 1'b0;
            end
        end
    end

    assign bus_if.f1_rd_en_o = pop1_c;
    assign bus_if.f2_rd_en_o = pop2_c;
    assign bus_if.wr_en_o    = pop1_c | pop2_c;
    assign bus_if.wr_data_o  = wr_data_c;
    assign gnt_o             = gnt_q;
    assign pkt_cnt1_o        = cnt1_q;
    assign pkt_cnt2_o        = cnt2_q;

endmodule

// File: tb/tb_fifo_arb_tx.sv
// Scoreboard bench for fifo_arb_tx: FIFO models feed random traffic, a packet-level
// reference predicts the sink stream and an independent monitor checks it.
module tb_fifo_arb_tx;
    localparam int unsigned DW  = 32;
    localparam logic [31:0] SEL = 32'h8000_0000;

    typedef struct {
        logic [31:0] d;
        int          src;
        bit          is_cmd;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  gnt;
    logic [15:0] cnt1, cnt2;

    fifo_arb_tx_if #(.DW(DW)) bus_if ();

    fifo_arb_tx #(
        .DW(DW), .SEL_MASK(SEL), .CNT_SHIFT(24), .CNT_MASK(4'hf)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .bus_if(bus_if),
        .gnt_o(gnt), .pkt_cnt1_o(cnt1), .pkt_cnt2_o(cnt2)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] s1[$];
    logic [31:0] s2[$];
    exp_t        exp_q[$];
    int          full_pct = 0;
    int          hide_pct = 0;
    bit          hide1 = 0, hide2 = 0;
    bit          vis1 = 0, vis2 = 0, full_now = 0;
    bit          pend1 = 0, pend2 = 0;
    int          m_last = 2;
    logic [15:0] m_cnt1 = '0, m_cnt2 = '0;
    int          n_wr = 0;
    int          first_wr = -1, last_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Payload length from the command code: 0..2 literal, 3 -> 4, 4 -> 8, else none.
    function automatic int pkt_len(input logic [31:0] cmd);
        int code;
        code = int'((cmd >> 24) & 32'hf);
        if (code <= 2) return code;
        if (code <= 4) return 1 << (code - 1);
        return 0;
    endfunction

    // Packet-level reference: once the previous packet has fully left, the next
    // visible source (round-robin) contributes its whole packet to the scoreboard.
    task automatic model_step();
        int          src;
        int          len;
        logic [31:0] cmd;
        if (exp_q.size() != 0 || full_now) return;
        if (vis1 && (!vis2 || m_last == 2)) src = 1;
        else if (vis2) src = 2;
        else return;
        cmd = (src == 1) ? s1[0] : s2[0];
        len = pkt_len(cmd);
        exp_q.push_back('{(src == 1) ? (cmd | SEL) : (cmd & ~SEL), src, 1'b1});
        for (int i = 1; i <= len; i++)
            exp_q.push_back('{(src == 1) ? s1[i] : s2[i], src, 1'b0});
        if (src == 1) m_cnt1 = m_cnt1 + 16'd1;
        else          m_cnt2 = m_cnt2 + 16'd1;
        m_last = src;
    endtask

    // FIFO environment: apply last cycle's pops, then present heads/flags.
    initial begin : env
        bus_if.f1_empty_i   = 1'b1;
        bus_if.f2_empty_i   = 1'b1;
        bus_if.f1_rd_data_i = '0;
        bus_if.f2_rd_data_i = '0;
        bus_if.full_i       = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (pend1 && s1.size() > 0) void'(s1.pop_front());
            if (pend2 && s2.size() > 0) void'(s2.pop_front());
            pend1    = 1'b0;
            pend2    = 1'b0;
            full_now = ($urandom_range(99) < full_pct);
            vis1     = (s1.size() > 0) && !hide1 && ($urandom_range(99) >= hide_pct);
            vis2     = (s2.size() > 0) && !hide2 && ($urandom_range(99) >= hide_pct);
            bus_if.full_i       = full_now;
            bus_if.f1_empty_i   = !vis1;
            bus_if.f2_empty_i   = !vis2;
            bus_if.f1_rd_data_i = vis1 ? s1[0] : $urandom();
            bus_if.f2_rd_data_i = vis2 ? s2[0] : $urandom();
            if (rstn) model_step();
            @(negedge clk);
            pend1 = rstn && bus_if.f1_rd_en_o;
            pend2 = rstn && bus_if.f2_rd_en_o;
        end
    end

    // Monitor: compares every sink write against the scoreboard.
    initial begin : mon
        exp_t e;
        logic rd1, rd2, we, legal;
        forever begin
            @(negedge clk);
            if (rstn) begin
                rd1 = bus_if.f1_rd_en_o;
                rd2 = bus_if.f2_rd_en_o;
                we  = bus_if.wr_en_o;
                if (rd1 || rd2 || we) begin
                    legal = (we == (rd1 | rd2)) && !(rd1 && rd2) && !(we && bus_if.full_i)
                            && !(rd1 && bus_if.f1_empty_i) && !(rd2 && bus_if.f2_empty_i);
                    chk("handshake", 32'(legal), 32'd1);
                end
                if (we) begin
                    n_wr++;
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got %h expected no write", bus_if.wr_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_data", bus_if.wr_data_o, e.d);
                        chk("src_sel", 32'({rd2, rd1}), (e.src == 1) ? 32'd1 : 32'd2);
                        if (!e.is_cmd) chk("gnt_data", 32'(gnt), (e.src == 1) ? 32'd1 : 32'd2);
                    end
                end
            end
        end
    end

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((s1.size() != 0 || s2.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size() + s1.size() + s2.size());
        end
        @(negedge clk);
        chk({name, "_cnt1"}, 32'(cnt1), 32'(m_cnt1));
        chk({name, "_cnt2"}, 32'(cnt2), 32'(m_cnt2));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_wr_en"},   32'(bus_if.wr_en_o),    32'd0);
        chk({name, "_rd_en1"},  32'(bus_if.f1_rd_en_o), 32'd0);
        chk({name, "_rd_en2"},  32'(bus_if.f2_rd_en_o), 32'd0);
        chk({name, "_wr_data"}, bus_if.wr_data_o,       32'd0);
        chk({name, "_gnt"},     32'(gnt),               32'd0);
        chk({name, "_cnt1"},    32'(cnt1),              32'd0);
        chk({name, "_cnt2"},    32'(cnt2),              32'd0);
    endtask

    task automatic wait_writes(input string name, input int target, input int budget);
        for (int k = 0; k < budget && n_wr < target; k++) @(negedge clk);
        if (n_wr < target) begin
            total++;
            bad++;
            $display("FAIL %s_wait: got %0d writes expected %0d", name, n_wr, target);
        end
    endtask

    initial begin : main
        logic [31:0] cmd;
        int          code;
        // Reset with traffic already waiting; then both sources contend.
        for (int i = 0; i < 4; i++) begin
            s1.push_back(32'h0000_0001);
            s2.push_back(32'h0000_0001);
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        drain("contention", 100);
        chk("contention_cnt1", 32'(cnt1), 32'd4);
        chk("contention_cnt2", 32'(cnt2), 32'd4);

        // Single source, code 3: five back-to-back writes.
        n_wr = 0;
        first_wr = -1;
        s1.push_back(32'h0300_0000);
        for (int i = 1; i <= 4; i++) s1.push_back(32'h1111_0000 + 32'(i));
        drain("single", 100);
        chk("single_nwr", 32'(n_wr), 32'd5);
        chk("single_span", 32'(last_wr - first_wr), 32'd4);
        chk("single_cnt1", 32'(cnt1), 32'd5);

        // Atomicity: src2 code-4 packet stalls mid-way while src1 waits.
        n_wr = 0;
        s2.push_back(32'h8400_00AA);
        for (int i = 1; i <= 8; i++) s2.push_back(32'h2222_0000 + 32'(i));
        s1.push_back(32'h0100_0000);
        s1.push_back(32'h3333_0001);
        wait_writes("atomic", 4, 50);
        hide2 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_gnt", 32'(gnt), 32'd2);
            chk("stall_no_src1", 32'(bus_if.f1_rd_en_o), 32'd0);
            chk("stall_no_wr", 32'(bus_if.wr_en_o), 32'd0);
        end
        hide2 = 1'b0;
        drain("atomic", 100);

        // Backpressure on a code-2 packet.
        n_wr = 0;
        full_pct = 50;
        s1.push_back(32'h0200_0000);
        s1.push_back(32'h4444_0001);
        s1.push_back(32'h4444_0002);
        drain("bp", 300);
        chk("bp_nwr", 32'(n_wr), 32'd3);
        full_pct = 0;

        // Invalid code 7 carries no payload; following word is a new command.
        n_wr = 0;
        s1.push_back(32'h0700_0000);
        s1.push_back(32'h0000_0005);
        drain("invalid", 50);
        chk("invalid_nwr", 32'(n_wr), 32'd2);

        // Random mix of codes, sources, empties and backpressure.
        full_pct = 30;
        hide_pct = 20;
        for (int p = 0; p < 60; p++) begin
            code = $urandom_range(7);
            cmd  = ($urandom() & 32'hf0ff_ffff) | (32'(code) << 24);
            if ($urandom_range(1) == 0) begin
                s1.push_back(cmd);
                for (int i = 0; i < pkt_len(cmd); i++) s1.push_back($urandom());
            end else begin
                s2.push_back(cmd);
                for (int i = 0; i < pkt_len(cmd); i++) s2.push_back($urandom());
            end
        end
        drain("random", 5000);
        full_pct = 0;
        hide_pct = 0;

        // Reset in the middle of a packet.
        n_wr = 0;
        s1.push_back(32'h0400_0000);
        for (int i = 1; i <= 8; i++) s1.push_back(32'h5555_0000 + 32'(i));
        wait_writes("midrst", 3, 50);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk_reset_outputs("midrst");
        s1.delete();
        s2.delete();
        exp_q.delete();
        m_last = 2;
        m_cnt1 = '0;
        m_cnt2 = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("postrst_gnt", 32'(gnt), 32'd0);
        s1.push_back(32'h0100_0000);
        s1.push_back(32'h6666_0001);
        drain("postrst", 50);
        chk("postrst_cnt1", 32'(cnt1), 32'd1);

        // 65536 more src1 packets wrap the counter back to its start value.
        for (int i = 0; i < 65536; i++) s1.push_back(32'h0000_0000);
        drain("wrap", 70000);
        chk("wrap_cnt1", 32'(cnt1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
